time_bin_sequencer: RTL and testbench

- Downstream stage of the free-running PMT photon counter. Consumes the counter's 8-bit running total and slices it into a programmed number of equal-length time bins.
- Emits one photon count per bin as a modular difference of counter samples, so the upstream counter is never cleared.
- Per-bin counts are buffered in a small FIFO with a valid/ready output toward the readout/UART stage.

---
 rtl/tbs_pkg.sv | 17 +
 rtl/bin_fifo.sv | 67 ++++++
 rtl/time_bin_sequencer.sv | 145 ++++++++++++++
 tb/tb_time_bin_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tbs_pkg.sv
// Shared definitions for the time-bin sequencer: FSM state encoding and
// default widths/depth used as parameter defaults by the top and its FIFO.
// No ports; imported by time_bin_sequencer.
package tbs_pkg;

  localparam int DEF_COUNT_W    = 8;   // photon count / bin word width
  localparam int DEF_BIN_W      = 16;  // bin length width (clk cycles)
  localparam int DEF_NBIN_W     = 8;   // bins-per-acquisition width
  localparam int DEF_FIFO_DEPTH = 16;  // output buffer depth, power of two

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } tbs_state_e;

endpackage

// File: rtl/bin_fifo.sv
// Synchronous first-word-fall-through FIFO for per-bin count words.
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read
// side, empty/full flags and level (words stored, 0..DEPTH).
module bin_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  // Head word is presented combinationally; forced to zero while empty so
  // the read side never shows stale or uninitialised storage.
  assign dout = empty ? '0 : mem[rd_q];

  // A pop of an empty FIFO is ignored. A push into a full FIFO only
  // succeeds when a pop frees a slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by level_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

endmodule

// File: rtl/time_bin_sequencer.sv
// Slices a free-running wrapping photon total into num_bins bins of bin_len
// cycles and queues one modular-difference count per bin toward readout.
// Ports: clk/reset (sync, active-high); count_in; start/abort/bin_len/
// num_bins control; out_data/out_valid/out_ready stream; fifo_level, busy,
// done (1-cycle pulse), dropped (sticky FIFO-overflow flag).
module time_bin_sequencer
  import tbs_pkg::*;
#(
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int BIN_W      = DEF_BIN_W,
  parameter int NBIN_W     = DEF_NBIN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [COUNT_W-1:0]          count_in,
  input  logic                        start,
  input  logic                        abort,
  input  logic [BIN_W-1:0]            bin_len,
  input  logic [NBIN_W-1:0]           num_bins,
  output logic [COUNT_W-1:0]          out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        done,
  output logic                        dropped
);

  tbs_state_e         state_q, state_d;
  logic [BIN_W-1:0]   len_q, len_d;
  logic [NBIN_W-1:0]  nb_q, nb_d;
  logic [COUNT_W-1:0] base_q, base_d;
  logic [BIN_W-1:0]   timer_q, timer_d;
  logic [NBIN_W-1:0]  idx_q, idx_d;
  logic               dropped_q, dropped_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [COUNT_W-1:0] delta;
  logic               bin_close;
  logic               last_bin;

  // Unsigned COUNT_W subtraction gives the count mod 2^COUNT_W, so the
  // upstream counter can wrap freely and is never cleared.
  assign delta     = count_in - base_q;
  assign bin_close = (timer_q == len_q - BIN_W'(1));
  assign last_bin  = (idx_q == nb_q - NBIN_W'(1));
  assign fifo_pop  = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    nb_d      = nb_q;
    base_d    = base_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    dropped_d = dropped_q;
    fifo_push = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A zero length or zero bin count is not a valid acquisition.
        if (start && (bin_len != '0) && (num_bins != '0)) begin
          state_d   = RUN;
          len_d     = bin_len;
          nb_d      = num_bins;
          base_d    = count_in;
          timer_d   = '0;
          idx_d     = '0;
          dropped_d = 1'b0;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (abort) begin
          // Abort beats a coincident bin close: the partial bin is lost.
          state_d = IDLE;
        end else if (bin_close) begin
          fifo_push = 1'b1;
          base_d    = count_in;
          timer_d   = '0;
          idx_d     = idx_q + NBIN_W'(1);
          if (last_bin) state_d = FINISH;
        end else begin
          timer_d = timer_q + BIN_W'(1);
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // The FIFO silently discards a push it cannot accept; remember it here.
    if (fifo_push && fifo_full && !fifo_pop) dropped_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      nb_q      <= '0;
      base_q    <= '0;
      timer_q   <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      nb_q      <= nb_d;
      base_q    <= base_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

  assign dropped   = dropped_q;
  assign out_valid = !fifo_empty;

  bin_fifo #(
    .WIDTH (COUNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (delta),
    .dout  (out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_time_bin_sequencer.sv
// Directed bench for time_bin_sequencer: expected bin words are queued as
// stimulus is issued and checked by an independent output monitor; control
// and status outputs are checked inline after the relevant edges.
module tb_time_bin_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  count_in;
  logic        start;
  logic        abort;
  logic [15:0] bin_len;
  logic [7:0]  num_bins;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_level;
  logic        busy;
  logic        done;
  logic        dropped;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        cnt_en   = 1'b0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  time_bin_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .count_in   (count_in),
    .start      (start),
    .abort      (abort),
    .bin_len    (bin_len),
    .num_bins   (num_bins),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .busy       (busy),
    .done       (done),
    .dropped    (dropped)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Output monitor: every accepted word is compared with the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %0d, expected no word", out_data);
      end else begin
        chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  // One clock; inputs change 1 time unit after the edge, and the optional
  // counter model advances by one per cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_en) count_in = count_in + 8'd1;
  endtask

  task automatic start_acq(input logic [15:0] len, input logic [7:0] nb,
                           input logic [7:0] cnt0);
    bin_len  = len;
    num_bins = nb;
    count_in = cnt0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_drain: %0d words still outstanding, expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    count_in  = 8'd0;
    start     = 1'b0;
    abort     = 1'b0;
    bin_len   = 16'd0;
    num_bins  = 8'd0;
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dropped", int'(dropped), 0);
    reset = 1'b0;
    tick();

    // Basic run: count 10,11,12,... ; 3 bins of 4 cycles -> 4,4,4
    cnt_en = 1'b1;
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd4);
    start_acq(16'd4, 8'd3, 8'd10);                 // passed E0
    chk("basic_busy_start", int'(busy), 1);
    repeat (3) tick();                              // passed E0+3
    chk("basic_no_word_yet", int'(out_valid), 0);
    tick();                                         // passed E0+4 (close 0)
    chk("basic_fwft_valid", int'(out_valid), 1);
    chk("basic_fwft_data", int'(out_data), 4);
    repeat (7) tick();                              // passed E0+11
    chk("basic_busy_e11", int'(busy), 1);
    chk("basic_done_e11", int'(done), 0);
    tick();                                         // passed E0+12 (last close)
    chk("basic_done_pulse", int'(done), 1);
    chk("basic_busy_fall", int'(busy), 0);
    tick();
    chk("basic_done_once", int'(done), 0);
    wait_drain("basic");

    // Wrap: 250 at start, 5 at the close edge -> 11
    cnt_en    = 1'b0;
    exp_q.push_back(8'd11);
    start_acq(16'd8, 8'd1, 8'd250);
    repeat (7) tick();                              // passed E0+7
    count_in = 8'd5;
    tick();                                         // passed E0+8 (close)
    chk("wrap_done", int'(done), 1);
    wait_drain("wrap");

    // Backpressure: 20 bins of 2 cycles, deltas 1..20, only 1..16 kept
    out_ready = 1'b0;
    start_acq(16'd2, 8'd20, 8'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      count_in = 8'((k + 1) * (k + 2) / 2);         // running sum of 1..k+1
      if (k < 16) exp_q.push_back(8'(k + 1));
      tick();                                       // close of bin k
      if (k == 15) begin
        chk("bp_level_at_16", int'(fifo_level), 16);
        chk("bp_dropped_before", int'(dropped), 0);
      end
      if (k == 16) chk("bp_dropped_set", int'(dropped), 1);
    end
    chk("bp_done", int'(done), 1);
    chk("bp_level_full", int'(fifo_level), 16);
    chk("bp_dropped_sticky", int'(dropped), 1);
    chk("bp_head", int'(out_data), 1);
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_valid_after_drain", int'(out_valid), 0);
    chk("bp_level_after_drain", int'(fifo_level), 0);

    // Illegal configuration: bin_len=0, then num_bins=0
    start_acq(16'd0, 8'd3, 8'd0);
    chk("ill_len0_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_len0_done", int'(done), 0);
    end
    start_acq(16'd4, 8'd0, 8'd0);
    chk("ill_nb0_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_nb0_done", int'(done), 0);
    end
    chk("ill_dropped_kept", int'(dropped), 1);

    // Abort one cycle before bin 2 closes: exactly two words
    cnt_en = 1'b1;
    exp_q.push_back(8'd3);
    exp_q.push_back(8'd3);
    start_acq(16'd3, 8'd5, 8'd100);
    chk("abort_dropped_cleared", int'(dropped), 0);
    repeat (7) tick();                              // passed E0+7
    abort = 1'b1;
    tick();                                         // passed E0+8
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_done", int'(done), 0);
    end
    wait_drain("abort");
    chk("abort_level", int'(fifo_level), 0);

    // Reset mid-run with one word queued, then a clean new run
    out_ready = 1'b0;
    start_acq(16'd4, 8'd3, 8'd0);
    repeat (4) tick();                              // passed E0+4 (close 0)
    chk("rstrun_level_before", int'(fifo_level), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrun_out_data", int'(out_data), 0);
    chk("rstrun_out_valid", int'(out_valid), 0);
    chk("rstrun_level", int'(fifo_level), 0);
    chk("rstrun_busy", int'(busy), 0);
    chk("rstrun_done", int'(done), 0);
    chk("rstrun_dropped", int'(dropped), 0);
    out_ready = 1'b1;
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd2);
    start_acq(16'd2, 8'd2, 8'd50);
    chk("rerun_busy", int'(busy), 1);
    repeat (4) tick();                              // passed E0+4 (last close)
    chk("rerun_done", int'(done), 1);
    wait_drain("rerun");
    chk("rerun_level", int'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
